// File: rtl/video_checker_pkg.sv
// Shared types and constants for the AXI4-Stream video frame checker.
package video_checker_pkg;

    typedef enum logic [0:0] {
        WAIT_SOF = 1'b0,
        IN_FRAME = 1'b1
    } state_e;

    localparam int ERR_NO_SOF     = 0;
    localparam int ERR_EARLY_SOF  = 1;
    localparam int ERR_SHORT_LINE = 2;
    localparam int ERR_LONG_LINE  = 3;

    // At most one SOF-class and one line-class error can coincide on a beat.
    function automatic logic [1:0] err_event_count(input logic [3:0] errs);
        return {1'b0, errs[ERR_NO_SOF] | errs[ERR_EARLY_SOF]} +
               {1'b0, errs[ERR_SHORT_LINE] | errs[ERR_LONG_LINE]};
    endfunction

endpackage

// File: rtl/video_checker_sat_counter.sv
// Saturating event counter; clear restarts the count from this cycle's increment.
module video_checker_sat_counter #(
    parameter int WIDTH     = 16,
    parameter int INC_WIDTH = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 clear_i,
    input  logic [INC_WIDTH-1:0] inc_i,
    output logic [WIDTH-1:0]     count_o
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;
    logic [WIDTH-1:0] base_s;
    logic [WIDTH:0]   sum_s;

    // Next count: add the increment to either zero or the held value, clamp on carry-out.
    always_comb begin
        base_s  = {WIDTH{1'b0}};
        sum_s   = {(WIDTH+1){1'b0}};
        count_d = count_q;
        if (clear_i) begin
            base_s = {WIDTH{1'b0}};
        end else begin
            base_s = count_q;
        end
        sum_s = {1'b0, base_s} + {{(WIDTH+1-INC_WIDTH){1'b0}}, inc_i};
        if (sum_s[WIDTH]) begin
            count_d = {WIDTH{1'b1}};
        end else begin
            count_d = sum_s[WIDTH-1:0];
        end
    end

    // Count register.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= {WIDTH{1'b0}};
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/video_axi4s_frame_checker.sv
// AXI4-Stream video sink: measures frame geometry and checksum, flags framing errors.
module video_axi4s_frame_checker
    import video_checker_pkg::*;
#(
    parameter int TUSER_WIDTH     = 1,
    parameter int TDATA_WIDTH     = 24,
    parameter int X_WIDTH         = 12,
    parameter int Y_WIDTH         = 12,
    parameter int FRAME_CNT_WIDTH = 16,
    parameter int ERR_CNT_WIDTH   = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [X_WIDTH-1:0]         param_width,
    input  logic [Y_WIDTH-1:0]         param_height,
    input  logic                       clear,
    input  logic [TUSER_WIDTH-1:0]     s_axi4s_tuser,
    input  logic                       s_axi4s_tlast,
    input  logic [TDATA_WIDTH-1:0]     s_axi4s_tdata,
    input  logic                       s_axi4s_tvalid,
    output logic                       s_axi4s_tready,
    output logic                       frame_done,
    output logic [FRAME_CNT_WIDTH-1:0] frame_count,
    output logic [X_WIDTH-1:0]         frame_width,
    output logic [Y_WIDTH-1:0]         frame_height,
    output logic [31:0]                frame_checksum,
    output logic [3:0]                 err_flags,
    output logic [ERR_CNT_WIDTH-1:0]   err_count
);

    localparam logic [X_WIDTH-1:0]         X_ONE = {{(X_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [Y_WIDTH-1:0]         Y_ONE = {{(Y_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [FRAME_CNT_WIDTH-1:0] F_ONE = {{(FRAME_CNT_WIDTH-1){1'b0}}, 1'b1};

    state_e                     state_q, state_d;
    logic                       tready_q;
    logic [X_WIDTH-1:0]         w_q, w_d, x_q, x_d;
    logic [Y_WIDTH-1:0]         h_q, h_d, y_q, y_d;
    logic [31:0]                sum_q, sum_d;
    logic                       done_q, done_d;
    logic [FRAME_CNT_WIDTH-1:0] fcnt_q, fcnt_d;
    logic [X_WIDTH-1:0]         fw_q, fw_d;
    logic [Y_WIDTH-1:0]         fh_q, fh_d;
    logic [31:0]                fsum_q, fsum_d;
    logic [3:0]                 flags_q, flags_d;

    logic                       accept_s;
    logic                       sof_s;
    logic                       take_s;
    logic [31:0]                pixel_s;
    logic [X_WIDTH-1:0]         cur_x_s, cur_w_s;
    logic [Y_WIDTH-1:0]         cur_y_s, cur_h_s;
    logic [31:0]                cur_sum_s;
    logic                       at_end_s, line_end_s, last_line_s;
    logic [3:0]                 new_err_s;

    assign accept_s = s_axi4s_tvalid && tready_q;
    assign sof_s    = s_axi4s_tuser[0];
    assign pixel_s  = 32'(s_axi4s_tdata);

    // Beat position: an SOF beat always restarts at pixel (0,0) with freshly latched geometry.
    always_comb begin
        cur_x_s   = x_q;
        cur_y_s   = y_q;
        cur_w_s   = w_q;
        cur_h_s   = h_q;
        cur_sum_s = sum_q;
        if (sof_s) begin
            cur_x_s   = {X_WIDTH{1'b0}};
            cur_y_s   = {Y_WIDTH{1'b0}};
            cur_w_s   = param_width;
            cur_h_s   = param_height;
            cur_sum_s = pixel_s;
        end else begin
            cur_sum_s = sum_q + pixel_s;
        end
        at_end_s    = (cur_x_s == (cur_w_s - X_ONE));
        line_end_s  = s_axi4s_tlast || at_end_s;
        last_line_s = (cur_y_s == (cur_h_s - Y_ONE));
    end

    // Next-state, error detection and frame statistics.
    always_comb begin
        state_d   = state_q;
        w_d       = w_q;
        h_d       = h_q;
        x_d       = x_q;
        y_d       = y_q;
        sum_d     = sum_q;
        done_d    = 1'b0;
        fcnt_d    = fcnt_q;
        fw_d      = fw_q;
        fh_d      = fh_q;
        fsum_d    = fsum_q;
        new_err_s = 4'b0000;
        take_s    = 1'b0;

        if (accept_s) begin
            case (state_q)
                WAIT_SOF: begin
                    take_s                = sof_s;
                    new_err_s[ERR_NO_SOF] = !sof_s;
                end
                IN_FRAME: begin
                    take_s                   = 1'b1;
                    new_err_s[ERR_EARLY_SOF] = sof_s;
                end
                default: begin
                    take_s = 1'b0;
                end
            endcase
        end else begin
            take_s = 1'b0;
        end

        if (take_s) begin
            new_err_s[ERR_SHORT_LINE] = s_axi4s_tlast && !at_end_s;
            new_err_s[ERR_LONG_LINE]  = at_end_s && !s_axi4s_tlast;
            w_d   = cur_w_s;
            h_d   = cur_h_s;
            sum_d = cur_sum_s;
            if (line_end_s) begin
                x_d = {X_WIDTH{1'b0}};
                y_d = cur_y_s + Y_ONE;
            end else begin
                x_d = cur_x_s + X_ONE;
                y_d = cur_y_s;
            end
            if (line_end_s && last_line_s) begin
                done_d  = 1'b1;
                fcnt_d  = fcnt_q + F_ONE;
                fw_d    = cur_x_s + X_ONE;
                fh_d    = cur_y_s + Y_ONE;
                fsum_d  = cur_sum_s;
                state_d = WAIT_SOF;
            end else begin
                state_d = IN_FRAME;
            end
        end else begin
            state_d = state_q;
        end

        // A coincident clear loses to errors raised on the same beat.
        if (clear) begin
            flags_d = new_err_s;
        end else begin
            flags_d = flags_q | new_err_s;
        end
    end

    // State and statistics registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= WAIT_SOF;
            tready_q <= 1'b0;
            w_q      <= {X_WIDTH{1'b0}};
            h_q      <= {Y_WIDTH{1'b0}};
            x_q      <= {X_WIDTH{1'b0}};
            y_q      <= {Y_WIDTH{1'b0}};
            sum_q    <= 32'd0;
            done_q   <= 1'b0;
            fcnt_q   <= {FRAME_CNT_WIDTH{1'b0}};
            fw_q     <= {X_WIDTH{1'b0}};
            fh_q     <= {Y_WIDTH{1'b0}};
            fsum_q   <= 32'd0;
            flags_q  <= 4'b0000;
        end else begin
            state_q  <= state_d;
            tready_q <= 1'b1;
            w_q      <= w_d;
            h_q      <= h_d;
            x_q      <= x_d;
            y_q      <= y_d;
            sum_q    <= sum_d;
            done_q   <= done_d;
            fcnt_q   <= fcnt_d;
            fw_q     <= fw_d;
            fh_q     <= fh_d;
            fsum_q   <= fsum_d;
            flags_q  <= flags_d;
        end
    end

    video_checker_sat_counter #(
        .WIDTH     (ERR_CNT_WIDTH),
        .INC_WIDTH (2)
    ) u_err_cnt (
        .clk     (clk),
        .reset   (reset),
        .clear_i (clear),
        .inc_i   (err_event_count(new_err_s)),
        .count_o (err_count)
    );

    assign s_axi4s_tready = tready_q;
    assign frame_done     = done_q;
    assign frame_count    = fcnt_q;
    assign frame_width    = fw_q;
    assign frame_height   = fh_q;
    assign frame_checksum = fsum_q;
    assign err_flags      = flags_q;

endmodule

// File: tb/tb_video_axi4s_frame_checker.sv
// Table-driven bench for video_axi4s_frame_checker; a 3-bit error counter exposes saturation.
module tb_video_axi4s_frame_checker;

    logic        clk = 1'b0;
    logic        reset;
    logic [11:0] param_width;
    logic [11:0] param_height;
    logic        clear;
    logic [0:0]  tuser;
    logic        tlast;
    logic [23:0] tdata;
    logic        tvalid;
    logic        tready;
    logic        frame_done;
    logic [15:0] frame_count;
    logic [11:0] frame_width;
    logic [11:0] frame_height;
    logic [31:0] frame_checksum;
    logic [3:0]  err_flags;
    logic [2:0]  err_count;

    always #5 clk = ~clk;

    video_axi4s_frame_checker #(
        .TUSER_WIDTH     (1),
        .TDATA_WIDTH     (24),
        .X_WIDTH         (12),
        .Y_WIDTH         (12),
        .FRAME_CNT_WIDTH (16),
        .ERR_CNT_WIDTH   (3)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .param_width    (param_width),
        .param_height   (param_height),
        .clear          (clear),
        .s_axi4s_tuser  (tuser),
        .s_axi4s_tlast  (tlast),
        .s_axi4s_tdata  (tdata),
        .s_axi4s_tvalid (tvalid),
        .s_axi4s_tready (tready),
        .frame_done     (frame_done),
        .frame_count    (frame_count),
        .frame_width    (frame_width),
        .frame_height   (frame_height),
        .frame_checksum (frame_checksum),
        .err_flags      (err_flags),
        .err_count      (err_count)
    );

    typedef struct {
        logic        rst, clr, vld, usr, lst;
        logic [23:0] data;
        logic [11:0] pw, ph;
        logic        rdy, done;
        logic [15:0] fcnt;
        logic [11:0] w, h;
        logic [31:0] sum;
        logic [3:0]  flags;
        logic [2:0]  ecnt;
    } vec_t;

    vec_t vecs[$];

    // Expected outputs after the next recorded edge, maintained by hand while filling the table.
    logic [11:0] cur_pw, cur_ph;
    logic        e_rdy;
    logic [15:0] e_fcnt;
    logic [11:0] e_w, e_h;
    logic [31:0] e_sum;
    logic [3:0]  e_flags;
    logic [2:0]  e_cnt;

    int n_pass  = 0;
    int n_total = 0;

    task automatic push(input logic rst, input logic clr, input logic vld, input logic usr,
                        input logic lst, input logic [23:0] data, input logic done);
        vec_t r;
        r.rst = rst;  r.clr = clr;  r.vld = vld;  r.usr = usr;  r.lst = lst;  r.data = data;
        r.pw = cur_pw; r.ph = cur_ph; r.rdy = e_rdy; r.done = done;
        r.fcnt = e_fcnt; r.w = e_w; r.h = e_h; r.sum = e_sum;
        r.flags = e_flags; r.ecnt = e_cnt;
        vecs.push_back(r);
    endtask

    task automatic beat(input logic u, input logic l, input logic [23:0] d);
        push(1'b0, 1'b0, 1'b1, u, l, d, 1'b0);
    endtask

    task automatic fin(input logic u, input logic l, input logic [23:0] d,
                       input logic [11:0] w, input logic [11:0] h, input logic [31:0] s);
        e_fcnt = e_fcnt + 16'd1;
        e_w    = w;
        e_h    = h;
        e_sum  = s;
        push(1'b0, 1'b0, 1'b1, u, l, d, 1'b1);
    endtask

    task automatic clr_idle();
        e_flags = 4'b0000;
        e_cnt   = 3'd0;
        push(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 24'd0, 1'b0);
    endtask

    task automatic rst_rec(input logic vld);
        e_rdy = 1'b0; e_fcnt = 16'd0; e_w = 12'd0; e_h = 12'd0;
        e_sum = 32'd0; e_flags = 4'b0000; e_cnt = 3'd0;
        push(1'b1, 1'b0, vld, 1'b1, 1'b0, 24'h00ABCD, 1'b0);
    endtask

    task automatic idle();
        e_rdy = 1'b1;
        push(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 24'd0, 1'b0);
    endtask

    task automatic chk(input string name, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            $display("FAIL %s vec %0d: got %0h expected %0h", name, idx, act, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic clean_frame(input logic [31:0] sum_after);
        for (int i = 1; i <= 11; i++) begin
            beat(i == 1, (i % 4) == 0, 24'(i));
        end
        fin(1'b0, 1'b1, 24'd12, 12'd4, 12'd3, sum_after);
    endtask

    initial begin
        cur_pw = 12'd4;
        cur_ph = 12'd3;

        rst_rec(1'b0);
        rst_rec(1'b0);
        idle();

        // Clean 4x3 frame.
        clean_frame(32'd78);

        // Two garbage beats, then the clean frame.
        e_flags = 4'b0001; e_cnt = 3'd1; beat(1'b0, 1'b0, 24'd55);
        e_cnt = 3'd2;                    beat(1'b0, 1'b1, 24'd66);
        clean_frame(32'd78);
        clr_idle();

        // Short line 0 (tlast on beat 3): 11 beats, data 10..20.
        beat(1'b1, 1'b0, 24'd10);
        beat(1'b0, 1'b0, 24'd11);
        e_flags = 4'b0100; e_cnt = 3'd1; beat(1'b0, 1'b1, 24'd12);
        for (int i = 13; i <= 19; i++) begin
            beat(1'b0, i == 16, 24'(i));
        end
        fin(1'b0, 1'b1, 24'd20, 12'd4, 12'd3, 32'd165);
        clr_idle();

        // Early SOF on beat 6 followed by a full frame.
        for (int i = 0; i < 5; i++) begin
            beat(i == 0, i == 3, 24'(100 + i));
        end
        e_flags = 4'b0010; e_cnt = 3'd1; beat(1'b1, 1'b0, 24'd1);
        for (int i = 2; i <= 11; i++) begin
            beat(1'b0, (i % 4) == 0, 24'(i));
        end
        fin(1'b0, 1'b1, 24'd12, 12'd4, 12'd3, 32'd78);
        clr_idle();

        // tlast omitted on beat 4.
        for (int i = 1; i <= 11; i++) begin
            if (i == 4) begin
                e_flags = 4'b1000; e_cnt = 3'd1;
            end
            beat(i == 1, i == 8, 24'(i));
        end
        fin(1'b0, 1'b1, 24'd12, 12'd4, 12'd3, 32'd78);

        // Clear coincident with a short-line error.
        clr_idle();
        e_flags = 4'b0001; e_cnt = 3'd1; beat(1'b0, 1'b0, 24'd9);
        beat(1'b1, 1'b0, 24'd1);
        e_flags = 4'b0100; e_cnt = 3'd1;
        push(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 24'd1, 1'b0);
        for (int i = 1; i <= 7; i++) begin
            beat(1'b0, i == 4, 24'd1);
        end
        fin(1'b0, 1'b1, 24'd1, 12'd4, 12'd3, 32'd10);

        // Saturation, including a two-error beat (early SOF + short line).
        e_flags = 4'b0101;
        for (int i = 2; i <= 6; i++) begin
            e_cnt = 3'(i); beat(1'b0, 1'b0, 24'd3);
        end
        beat(1'b1, 1'b0, 24'd0);
        e_flags = 4'b0111; e_cnt = 3'd7; beat(1'b1, 1'b1, 24'd0);
        beat(1'b1, 1'b1, 24'd0);
        beat(1'b0, 1'b0, 24'd4);

        // Reset mid-frame: nothing reported, back to WAIT_SOF.
        rst_rec(1'b1);
        idle();
        e_flags = 4'b0001; e_cnt = 3'd1; beat(1'b0, 1'b0, 24'd8);
        clr_idle();

        // Parameter change mid-frame takes effect only at the next SOF.
        beat(1'b1, 1'b0, 24'd1);
        cur_pw = 12'd1; cur_ph = 12'd1;
        for (int i = 2; i <= 11; i++) begin
            beat(1'b0, (i % 4) == 0, 24'(i));
        end
        fin(1'b0, 1'b1, 24'd12, 12'd4, 12'd3, 32'd78);

        // Back-to-back 1x1 frames; the second misses tlast.
        fin(1'b1, 1'b1, 24'd5, 12'd1, 12'd1, 32'd5);
        e_flags = 4'b1000; e_cnt = 3'd1;
        fin(1'b1, 1'b0, 24'd7, 12'd1, 12'd1, 32'd7);

        // 257x1 frame of all-ones pixels: checksum wraps.
        cur_pw = 12'd257;
        for (int i = 0; i < 256; i++) begin
            beat(i == 0, 1'b0, 24'hFFFFFF);
        end
        fin(1'b0, 1'b1, 24'hFFFFFF, 12'd257, 12'd1, 32'h00FFFEFF);
        idle();

        // Apply and compare.
        for (int i = 0; i < vecs.size(); i++) begin
            reset        = vecs[i].rst;
            clear        = vecs[i].clr;
            tvalid       = vecs[i].vld;
            tuser        = vecs[i].usr;
            tlast        = vecs[i].lst;
            tdata        = vecs[i].data;
            param_width  = vecs[i].pw;
            param_height = vecs[i].ph;
            @(posedge clk);
            #1;
            chk("tready",   i, 32'(tready),         32'(vecs[i].rdy));
            chk("done",     i, 32'(frame_done),     32'(vecs[i].done));
            chk("count",    i, 32'(frame_count),    32'(vecs[i].fcnt));
            chk("width",    i, 32'(frame_width),    32'(vecs[i].w));
            chk("height",   i, 32'(frame_height),   32'(vecs[i].h));
            chk("checksum", i, frame_checksum,      vecs[i].sum);
            chk("flags",    i, 32'(err_flags),      32'(vecs[i].flags));
            chk("errcnt",   i, 32'(err_count),      32'(vecs[i].ecnt));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/video_axi4s_frame_checker.md
# video_axi4s_frame_checker

Synthesizable AXI4-Stream video sink. It terminates the pixel stream produced by the video pipelines (the consuming end of the stream a video source emits) and measures frame geometry, a per-frame checksum and framing errors. It sits at the tail of the MNIST video path, or at any stream tap, so that on-chip self-test and simulation can check frames without a file-writing model.

## Interface

**Parameters**
- `TUSER_WIDTH`, default 1: tuser width; bit 0 is start-of-frame.
- `TDATA_WIDTH`, default 24: pixel width; must be ≤ 32.
- `X_WIDTH`, default 12: width of the column counter and `param_width`.
- `Y_WIDTH`, default 12: width of the line counter and `param_height`.
- `FRAME_CNT_WIDTH`, default 16: width of the completed-frame counter.
- `ERR_CNT_WIDTH`, default 16: width of the error-event counter.

**Ports**
- `clk`, input, 1: the only clock.
- `reset`, input, 1: synchronous, active-high.
- `param_width`, input, X_WIDTH: expected pixels per line, ≥ 1.
- `param_height`, input, Y_WIDTH: expected lines per frame, ≥ 1.
- `clear`, input, 1: one-cycle pulse; clears `err_flags` and `err_count`.
- `s_axi4s_tuser`, input, TUSER_WIDTH: start-of-frame marker.
- `s_axi4s_tlast`, input, 1: end-of-line marker.
- `s_axi4s_tdata`, input, TDATA_WIDTH: pixel.
- `s_axi4s_tvalid`, input, 1: beat valid.
- `s_axi4s_tready`, output, 1: accept.
- `frame_done`, output, 1: one-cycle pulse when a frame completes.
- `frame_count`, output, FRAME_CNT_WIDTH: number of completed frames.
- `frame_width`, output, X_WIDTH: pixel count of the last line of the last completed frame.
- `frame_height`, output, Y_WIDTH: line count of the last completed frame.
- `frame_checksum`, output, 32: mod-2^32 sum of tdata over the last completed frame.
- `err_flags`, output, 4: sticky framing-error flags.
- `err_count`, output, ERR_CNT_WIDTH: error-event counter; saturates.

## Operation

- **Beat acceptance:** a beat is accepted when `s_axi4s_tvalid && s_axi4s_tready`. All actions below happen on accepted beats only.
- **`s_axi4s_tready`:** 0 during reset and 1 from the first cycle after reset. The block never back-pressures.
- **State `WAIT_SOF`** (reset state):
  - A beat without tuser[0] is discarded. It sets `err_flags[0]` (missing SOF) and increments `err_count`.
  - A beat with tuser[0] latches `param_width` and `param_height`, sets x=0, y=0, loads the checksum with tdata, and moves to `IN_FRAME`. That beat is then processed as pixel (0,0) using the line-end rules below.
- **State `IN_FRAME`:**
  - **Early SOF:** a beat with tuser[0] sets `err_flags[1]` and increments `err_count`. The frame restarts with this beat as pixel (0,0). The partial frame is not reported.
  - **Normal pixel:** otherwise, tdata is added to the checksum.
  - **Line end:** a line ends on tlast, or at x == width-1.
    - tlast with x < width-1 sets `err_flags[2]` (short line).
    - x == width-1 without tlast sets `err_flags[3]` (long/missing tlast).
    - Each event increments `err_count` once.
    - At line end: x←0, y←y+1. Otherwise x←x+1.
  - **Frame end:** a line end with y == height-1 completes the frame:
    - register `frame_width` = x+1, `frame_height` = y+1, `frame_checksum`;
    - increment `frame_count` (it wraps);
    - pulse `frame_done`;
    - go to `WAIT_SOF`.
- **Checksum:** tdata is zero-extended to 32 bits; the sum wraps mod 2^32.
- **Error counting:** `err_count` saturates at all-ones. When two errors occur on one beat, it adds 2, saturating.
- **`clear`:** if a new error occurs in the same cycle, the new error wins: its flag is set, and `err_count` restarts from the new event count.
- **Parameter changes:** `param_width`/`param_height` changes take effect only at the next accepted SOF.

## Timing

- **Reset values:**
  - `s_axi4s_tready`=0 and `frame_done`=0.
  - `frame_count`, `frame_width`, `frame_height`, `frame_checksum`, `err_flags` and `err_count` are all 0.
  - State is `WAIT_SOF`.
- **Statistics latency:** `frame_done` and all statistics update on the clock edge that accepts the frame's last beat, so they are visible the following cycle. The statistics hold until the next frame completes.
- **Error latency:** error flags and the counter update on the edge that accepts the offending beat.
- **Reset mid-frame:** the partial frame is discarded, with no `frame_done`.
- **Throughput:** one beat per cycle, sustained, with no bubbles between frames.

## Structure

- **Shared package `video_checker_pkg`:**
  - state enum (`WAIT_SOF`, `IN_FRAME`);
  - error-bit index constants `ERR_NO_SOF`=0, `ERR_EARLY_SOF`=1, `ERR_SHORT_LINE`=2, `ERR_LONG_LINE`=3.
- **Sub-module `video_checker_sat_counter`:** a parameterized saturating counter with increment amount and clear, used for `err_count`. Everything else is a single module.

## Test plan

- **Clean 4×3 frame:** tdata = 1..12, tuser on beat 1, tlast on beats 4, 8, 12. Required response:
  - `frame_done` fires once;
  - width=4, height=3, checksum=78, `frame_count`=1, `err_flags`=0.
- **Two garbage beats, then the clean frame:** `err_flags`=4'b0001, `err_count`=2, the frame is still reported with checksum 78.
- **tlast on beat 3** of line 0 (4×3 frame): `err_flags[2]`=1. The frame completes after 11 beats with height 3.
- **tuser reasserted on beat 6, followed by a full 12-beat frame:** `err_flags[1]`=1, `frame_count`=1, and the checksum covers only the last 12 beats.
- **tlast omitted on beat 4:** `err_flags[3]`=1, `err_count`=1, the frame still completes at beat 12.
- **Other checks:**
  - `clear` coincident with a short-line error leaves `err_flags`=4'b0100 and `err_count`=1.
  - reset asserted mid-frame yields no `frame_done`, and all outputs read 0.
